// File: rtl/chacha_stream_feeder.sv
// Stream front-end for chacha_core: packs 32-bit plaintext words into 512-bit blocks,
// sequences init/next with a running block counter and serialises the ciphertext back out.
module chacha_stream_feeder #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_load,
  input  logic [255:0] cfg_key,
  input  logic [63:0]  cfg_iv,
  input  logic [63:0]  cfg_ctr0,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic [63:0]  core_ctr,
  output logic [63:0]  core_iv,
  output logic [511:0] core_data_in,
  input  logic         core_ready,
  input  logic         core_data_out_valid,
  input  logic [511:0] core_data_out,
  output logic         busy,
  output logic         ctr_wrap,
  output logic         timeout_err
);

  // Handshakes: a word moves on s/m only in a cycle where valid and ready are both high;
  // a producer holding valid keeps its data/last unchanged until that cycle.
  typedef enum logic [1:0] {S_COLLECT, S_ISSUE, S_WAIT, S_DRAIN} state_e;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [4:0]     nwords_q, nwords_d;
  logic           last_flag_q, last_flag_d;
  logic           first_blk_q, first_blk_d;
  logic [63:0]    ctr_q, ctr_d;
  logic [63:0]    iv_q, iv_d;
  logic [255:0]   key_q, key_d;
  logic [511:0]   blk_in_q, blk_in_d;
  logic [511:0]   blk_out_q, blk_out_d;
  logic           ctr_wrap_q, ctr_wrap_d;
  logic           timeout_err_q, timeout_err_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           final_word;
  logic [31:0]    out_word;

  assign final_word = (({1'b0, idx_q} + 5'd1) == nwords_q);
  assign busy       = (state_q != S_COLLECT) || (idx_q != 4'd0);

  always_comb begin
    out_word = '0;
    for (int k = 0; k < 16; k++) begin
      if (idx_q == 4'(k)) out_word = blk_out_q[511-32*k -: 32];
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    nwords_d      = nwords_q;
    last_flag_d   = last_flag_q;
    first_blk_d   = first_blk_q;
    ctr_d         = ctr_q;
    iv_d          = iv_q;
    key_d         = key_q;
    blk_in_d      = blk_in_q;
    blk_out_d     = blk_out_q;
    ctr_wrap_d    = ctr_wrap_q;
    timeout_err_d = timeout_err_q;
    tmo_d         = tmo_q;
    s_ready       = 1'b0;
    core_init     = 1'b0;
    core_next     = 1'b0;

    if (cfg_load && !busy) begin
      key_d         = cfg_key;
      iv_d          = cfg_iv;
      ctr_d         = cfg_ctr0;
      first_blk_d   = 1'b1;
      ctr_wrap_d    = 1'b0;
      timeout_err_d = 1'b0;
    end

    unique case (state_q)
      S_COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // The first word of a block clears the buffer so short blocks carry zero padding.
          if (idx_q == 4'd0) blk_in_d = '0;
          for (int k = 0; k < 16; k++) begin
            if (idx_q == 4'(k)) blk_in_d[511-32*k -: 32] = s_data;
          end
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15 || s_last) begin
            nwords_d    = {1'b0, idx_q} + 5'd1;
            last_flag_d = s_last;
            idx_d       = '0;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (core_ready) begin
          core_init   = first_blk_q;
          core_next   = !first_blk_q;
          first_blk_d = 1'b0;
          tmo_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_data_out_valid) begin
          blk_out_d = core_data_out;
          ctr_d     = ctr_q + 64'd1;
          if (&ctr_q) ctr_wrap_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Core never answered: drop the block and restart the key schedule with init.
          timeout_err_d = 1'b1;
          first_blk_d   = 1'b1;
          idx_d         = '0;
          state_d       = S_COLLECT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (m_ready) begin
          if (final_word) begin
            idx_d   = '0;
            state_d = S_COLLECT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_COLLECT;
      idx_q         <= '0;
      nwords_q      <= '0;
      last_flag_q   <= 1'b0;
      first_blk_q   <= 1'b1;
      ctr_q         <= '0;
      iv_q          <= '0;
      key_q         <= '0;
      blk_in_q      <= '0;
      blk_out_q     <= '0;
      ctr_wrap_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      nwords_q      <= nwords_d;
      last_flag_q   <= last_flag_d;
      first_blk_q   <= first_blk_d;
      ctr_q         <= ctr_d;
      iv_q          <= iv_d;
      key_q         <= key_d;
      blk_in_q      <= blk_in_d;
      blk_out_q     <= blk_out_d;
      ctr_wrap_q    <= ctr_wrap_d;
      timeout_err_q <= timeout_err_d;
      tmo_q         <= tmo_d;
    end
  end

  assign m_valid      = (state_q == S_DRAIN);
  assign m_data       = m_valid ? out_word : 32'd0;
  assign m_last       = m_valid && last_flag_q && final_word;
  assign core_key     = key_q;
  assign core_iv      = iv_q;
  assign core_ctr     = ctr_q;
  assign core_data_in = blk_in_q;
  assign ctr_wrap     = ctr_wrap_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_chacha_stream_feeder.sv
// Bench for chacha_stream_feeder: stub core, message-level reference model and
// scoreboards for core requests and ciphertext words.
module tb_chacha_stream_feeder;

  localparam int TMO = 64;

  logic         clk;
  logic         reset_n;
  logic         cfg_load;
  logic [255:0] cfg_key;
  logic [63:0]  cfg_iv;
  logic [63:0]  cfg_ctr0;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_data;
  logic         m_valid, m_ready, m_last;
  logic [31:0]  m_data;
  logic         core_init, core_next;
  logic [255:0] core_key;
  logic [63:0]  core_ctr, core_iv;
  logic [511:0] core_data_in;
  logic         core_ready, core_data_out_valid;
  logic [511:0] core_data_out;
  logic         busy, ctr_wrap, timeout_err;

  chacha_stream_feeder #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_ctr0(cfg_ctr0),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_init(core_init), .core_next(core_next), .core_key(core_key),
    .core_ctr(core_ctr), .core_iv(core_iv), .core_data_in(core_data_in),
    .core_ready(core_ready), .core_data_out_valid(core_data_out_valid),
    .core_data_out(core_data_out),
    .busy(busy), .ctr_wrap(ctr_wrap), .timeout_err(timeout_err)
  );

  typedef struct {
    bit           is_init;
    logic [63:0]  ctr;
    logic [511:0] blk;
    logic [255:0] key;
    logic [63:0]  iv;
  } req_t;

  logic [32:0] exp_q[$];
  req_t        exp_req_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] mdl_key;
  logic [63:0]  mdl_iv, mdl_ctr;
  bit           mdl_first, mdl_wrap, mdl_tmo;

  bit stub_on, rand_ready, spur_req, cfg_join;
  int stub_lat;
  int m_mode;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ks(input logic [63:0] c, input int k);
    return (32'hA5A5_0000 + 32'(k)) ^ c[31:0] ^ c[63:32];
  endfunction

  task automatic mdl_reset();
    mdl_key = '0; mdl_iv = '0; mdl_ctr = '0;
    mdl_first = 1'b1; mdl_wrap = 1'b0; mdl_tmo = 1'b0;
  endtask

  task automatic mdl_cfg(input logic [255:0] k, input logic [63:0] v, input logic [63:0] c);
    mdl_key = k; mdl_iv = v; mdl_ctr = c;
    mdl_first = 1'b1; mdl_wrap = 1'b0; mdl_tmo = 1'b0;
  endtask

  // driver tasks
  task automatic cfg_pulse(input logic [255:0] k, input logic [63:0] v, input logic [63:0] c);
    cfg_key = k; cfg_iv = v; cfg_ctr0 = c; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    int g;
    g = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    if (cfg_join) cfg_load = 1'b1;
    @(negedge clk);
    while (!s_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("s_ready_wait", 512'(g < 3000), 512'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; cfg_load = 1'b0; cfg_join = 1'b0;
  endtask

  // Reference model: chunk the message into 16-word blocks and predict requests and outputs.
  task automatic send_msg(input int n, input bit inc, input bit respond, input bit gaps);
    logic [31:0] w[$];
    int   pos, nb;
    req_t r;
    pos = 0;
    for (int i = 0; i < n; i++) w.push_back(inc ? 32'(i) : $urandom());
    while (pos < n) begin
      nb = (n - pos > 16) ? 16 : n - pos;
      r.is_init = mdl_first; r.ctr = mdl_ctr; r.key = mdl_key; r.iv = mdl_iv;
      r.blk = '0;
      for (int k = 0; k < nb; k++) r.blk[511-32*k -: 32] = w[pos+k];
      exp_req_q.push_back(r);
      if (respond) begin
        for (int k = 0; k < nb; k++)
          exp_q.push_back({(pos + k == n - 1), w[pos+k] ^ ks(mdl_ctr, k)});
        if (mdl_ctr == 64'hFFFF_FFFF_FFFF_FFFF) mdl_wrap = 1'b1;
        mdl_ctr = mdl_ctr + 64'd1;
        mdl_first = 1'b0;
      end else begin
        mdl_first = 1'b1;
        mdl_tmo = 1'b1;
      end
      pos += nb;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_word(w[i], i == n - 1);
    end
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || exp_req_q.size() != 0 || busy) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_done", 512'(cyc < 5000), 512'(1));
    @(posedge clk); #1;
  endtask

  // stub core
  initial begin
    logic [511:0] stub_blk, stub_din;
    logic [63:0]  stub_ctr;
    int           stub_cnt;
    core_data_out_valid = 1'b0; core_data_out = '0; core_ready = 1'b0;
    stub_cnt = 0; stub_blk = '0; stub_din = '0; stub_ctr = '0;
    forever begin
      @(negedge clk);
      if (reset_n && (core_init || core_next) && stub_on) begin
        stub_cnt = stub_lat;
        stub_din = core_data_in;
        stub_ctr = core_ctr;
        for (int k = 0; k < 16; k++)
          stub_blk[511-32*k -: 32] = core_data_in[511-32*k -: 32] ^ ks(core_ctr, k);
      end
      @(posedge clk); #1;
      core_data_out_valid = 1'b0;
      if (!reset_n) stub_cnt = 0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          chk("core_hold_data_in", core_data_in, stub_din);
          chk("core_hold_ctr", 512'(core_ctr), 512'(stub_ctr));
          core_data_out_valid = 1'b1;
          core_data_out = stub_blk;
        end
      end else if (spur_req) begin
        core_data_out_valid = 1'b1;
        core_data_out = {16{$urandom()}};
        spur_req = 1'b0;
      end
      core_ready = (stub_cnt == 0) && (!rand_ready || $urandom_range(0, 3) != 0);
    end
  end

  // downstream ready: 0 hold low, 1 always, 2 toggle, 3 random
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (m_mode)
        0: m_ready = 1'b0;
        1: m_ready = 1'b1;
        2: m_ready = !m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard
  initial begin
    logic [32:0] e;
    logic [31:0] prev_data;
    bit          prev_stall, prev_last;
    req_t        r;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("m_hold_valid", 512'(m_valid), 512'(1));
          chk("m_hold_data", 512'(m_data), 512'(prev_data));
          chk("m_hold_last", 512'(m_last), 512'(prev_last));
        end
        if (m_valid && m_ready) begin
          chk("m_word_expected", 512'(exp_q.size() != 0), 512'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("m_data", 512'(m_data), 512'(e[31:0]));
            chk("m_last", 512'(m_last), 512'(e[32]));
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (core_init || core_next) begin
          chk("req_expected", 512'(exp_req_q.size() != 0), 512'(1));
          if (exp_req_q.size() != 0) begin
            r = exp_req_q.pop_front();
            chk("req_init", 512'(core_init), 512'(r.is_init));
            chk("req_next", 512'(core_next), 512'(!r.is_init));
            chk("req_ctr", 512'(core_ctr), 512'(r.ctr));
            chk("req_key", 512'(core_key), 512'(r.key));
            chk("req_iv", 512'(core_iv), 512'(r.iv));
            chk("req_data_in", core_data_in, r.blk);
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 512'(m_valid), 512'(0));
    chk({tag, "_m_data"}, 512'(m_data), 512'(0));
    chk({tag, "_m_last"}, 512'(m_last), 512'(0));
    chk({tag, "_core_init"}, 512'(core_init), 512'(0));
    chk({tag, "_core_next"}, 512'(core_next), 512'(0));
    chk({tag, "_core_key"}, 512'(core_key), 512'(0));
    chk({tag, "_core_ctr"}, 512'(core_ctr), 512'(0));
    chk({tag, "_core_iv"}, 512'(core_iv), 512'(0));
    chk({tag, "_core_data_in"}, core_data_in, 512'(0));
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_ctr_wrap"}, 512'(ctr_wrap), 512'(0));
    chk({tag, "_timeout_err"}, 512'(timeout_err), 512'(0));
  endtask

  initial begin
    logic [255:0] k;
    logic [63:0]  v;
    int           g;
    reset_n = 1'b0; cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_ctr0 = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    stub_on = 1'b1; stub_lat = 20; rand_ready = 1'b0; spur_req = 1'b0; cfg_join = 1'b0;
    m_mode = 1;
    mdl_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", 512'(s_ready), 512'(1));
    chk("idle_busy", 512'(busy), 512'(0));
    @(posedge clk); #1;

    // full block, counter 0, plaintext k
    k = {8{$urandom()}}; v = {2{$urandom()}};
    mdl_cfg(k, v, 64'd0); cfg_pulse(k, v, 64'd0);
    send_msg(16, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // partial block of 5 words
    send_msg(5, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // cfg_load coinciding with first word, then two full messages
    k = {8{$urandom()}}; v = {2{$urandom()}};
    cfg_key = k; cfg_iv = v; cfg_ctr0 = 64'd7; cfg_join = 1'b1;
    mdl_cfg(k, v, 64'd7);
    send_msg(16, 1'b0, 1'b1, 1'b0);
    send_msg(16, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // counter wrap across two blocks
    mdl_cfg(k, v, 64'hFFFF_FFFF_FFFF_FFFF); cfg_pulse(k, v, 64'hFFFF_FFFF_FFFF_FFFF);
    send_msg(20, 1'b0, 1'b1, 1'b0);
    wait_drain();
    chk("ctr_wrap_set", 512'(ctr_wrap), 512'(mdl_wrap));

    // backpressure 1010 during drain
    m_mode = 2;
    send_msg(16, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // randomized messages, latencies, core_ready and m_ready
    m_mode = 3; rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stub_lat = $urandom_range(1, 40);
      if ($urandom_range(0, 2) == 0) begin
        k = {8{$urandom()}}; v = {2{$urandom()}};
        g = $urandom();
        mdl_cfg(k, v, {32'd0, 32'(g)}); cfg_pulse(k, v, {32'd0, 32'(g)});
      end
      send_msg($urandom_range(1, 40), 1'b0, 1'b1, 1'b1);
      wait_drain();
    end
    chk("ctr_wrap_cleared", 512'(ctr_wrap), 512'(mdl_wrap));

    // cfg_load while busy is ignored
    stub_lat = 30;
    send_msg(6, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("busy_in_flight", 512'(busy), 512'(1));
    cfg_pulse({8{$urandom()}}, {2{$urandom()}}, 64'h1234);
    wait_drain();
    send_msg(3, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // unsolicited core_data_out_valid while idle
    spur_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("spur_busy", 512'(busy), 512'(0));
    chk("spur_m_valid", 512'(m_valid), 512'(0));
    @(posedge clk); #1;

    // core never responds
    m_mode = 1; rand_ready = 1'b0; stub_on = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    send_msg(16, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    repeat (TMO) @(negedge clk);
    chk("tmo_not_yet", 512'(timeout_err), 512'(0));
    chk("tmo_busy_before", 512'(busy), 512'(1));
    @(negedge clk);
    chk("tmo_err", 512'(timeout_err), 512'(mdl_tmo));
    chk("tmo_busy_after", 512'(busy), 512'(0));
    @(posedge clk); #1;
    stub_on = 1'b1; stub_lat = 8;
    send_msg(7, 1'b0, 1'b1, 1'b0);
    wait_drain();
    chk("tmo_sticky", 512'(timeout_err), 512'(mdl_tmo));
    k = {8{$urandom()}}; v = {2{$urandom()}};
    mdl_cfg(k, v, 64'd99); cfg_pulse(k, v, 64'd99);
    @(negedge clk);
    chk("tmo_cleared", 512'(timeout_err), 512'(mdl_tmo));
    @(posedge clk); #1;

    // reset in the middle of DRAIN
    m_mode = 0; stub_lat = 5;
    send_msg(4, 1'b0, 1'b1, 1'b0);
    g = 0;
    @(negedge clk);
    while (!m_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_reached", 512'(m_valid), 512'(1));
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    exp_q.delete();
    exp_req_q.delete();
    mdl_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_mode = 1;
    @(posedge clk); #1;
    k = {8{$urandom()}}; v = {2{$urandom()}};
    mdl_cfg(k, v, 64'd3); cfg_pulse(k, v, 64'd3);
    send_msg(9, 1'b0, 1'b1, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
